// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and status-word bit positions.
// The memory controller decodes the status word using the same indices.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int BUSY  = 0;
  localparam int EMPTY = 1;
  localparam int FULL  = 2;
  localparam int OVF   = 3;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, zero-latency read of the head entry; full/empty registered via count.
// Pushes when full are ignored unless a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dat   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: write strobe queues a byte, start bit falls two cycles later.
// Writes to a full FIFO (with no same-cycle pop) are dropped and set a sticky overflow flag.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  tx_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_ovf;

  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic          w_baud_end;
  logic          w_pop;
  logic          w_push;
  logic          w_unused_wdata;

  assign w_unused_wdata = ^WriteData[DATA_WIDTH-1:8];
  assign w_baud_end     = (r_baud == BW'(CLKS_PER_BIT - 1));
  // Pop exactly when the FSM is about to start a new frame.
  assign w_pop  = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));
  assign w_push = MemWrite && (!w_full || w_pop);

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (WriteData[7:0]),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (MemWrite && !w_push) r_ovf <= 1'b1;
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (r_state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = r_shift[0];
      default: tx_o = 1'b1;
    endcase
  end

  always_comb begin
    ReadData        = '0;
    ReadData[BUSY]  = (r_state != IDLE);
    ReadData[EMPTY] = w_empty;
    ReadData[FULL]  = w_full;
    ReadData[OVF]   = r_ovf;
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: queued expected bytes are matched against frames decoded from tx_o.
module tb_uart_tx_periph;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic        tx_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] sb_q[$];
  logic [7:0] rx_q[$];
  logic [9:0] rx_bits_q[$];
  int         rx_start_q[$];

  logic [9:0] mon_bits;
  int         mon_start;
  bit         mon_abort;

  uart_tx_periph #(
    .DATA_WIDTH   (32),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .tx_o      (tx_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame decoder: samples each bit mid-way, abandons the frame if reset is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_o === 1'b0) begin
        mon_start = cyc;
        mon_bits  = '0;
        mon_abort = 1'b0;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          if (reset) begin
            mon_abort = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) mon_bits[c / CPB] = tx_o;
        end
        if (!mon_abort) begin
          rx_q.push_back(mon_bits[8:1]);
          rx_bits_q.push_back(mon_bits);
          rx_start_q.push_back(mon_start);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    MemWrite = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    rx_q.delete();
    rx_bits_q.delete();
    rx_start_q.delete();
  endtask

  task automatic do_write(input logic [7:0] b);
    MemWrite  = 1'b1;
    WriteData = {24'hDEADBE, b};
    @(negedge clk);
    MemWrite  = 1'b0;
    WriteData = '0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (ReadData[BUSY] === 1'b0 && ReadData[EMPTY] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int lows;
    apply_reset();
    n_checks++;
    if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx_o); end
    n_checks++;
    if (ReadData !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h expected 00000002", ReadData); end
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL reset_idle_line: got %0d low cycles expected 0", lows); end
    n_checks++;
    if (ReadData !== 32'h2) begin n_fail++; $display("FAIL reset_status_hold: got %h expected 00000002", ReadData); end
  endtask

  task automatic test_single_byte();
    int busy;
    logic [7:0] e, g;
    logic [9:0] gb;
    apply_reset();
    sb_q.push_back(8'hA5);
    do_write(8'hA5);
    n_checks++;
    if (tx_o !== 1'b1 || ReadData !== 32'h0) begin
      n_fail++; $display("FAIL single_k1: got tx=%b status=%h expected tx=1 status=00000000", tx_o, ReadData);
    end
    @(negedge clk);
    n_checks++;
    if (tx_o !== 1'b0 || ReadData !== 32'h3) begin
      n_fail++; $display("FAIL single_k2: got tx=%b status=%h expected tx=0 status=00000003", tx_o, ReadData);
    end
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      if (ReadData[BUSY] !== 1'b1) break;
      busy++;
      @(negedge clk);
    end
    n_checks++;
    if (busy !== FRAME) begin n_fail++; $display("FAIL single_busy: got %0d cycles expected %0d", busy, FRAME); end
    n_checks++;
    if (ReadData !== 32'h2) begin n_fail++; $display("FAIL single_done_status: got %h expected 00000002", ReadData); end
    n_checks++;
    if (rx_q.size() !== 1) begin n_fail++; $display("FAIL single_frames: got %0d expected 1", rx_q.size()); end
    while (sb_q.size() > 0 && rx_q.size() > 0) begin
      e = sb_q.pop_front(); g = rx_q.pop_front(); gb = rx_bits_q.pop_front();
      n_checks++;
      if (g !== e || gb !== {1'b1, e, 1'b0}) begin
        n_fail++; $display("FAIL single_frame: got bits %b expected %b", gb, {1'b1, e, 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy;
    logic [7:0] e, g;
    logic [9:0] gb;
    apply_reset();
    sb_q.push_back(8'h55);
    sb_q.push_back(8'hFF);
    do_write(8'h55);
    do_write(8'hFF);
    busy = 0;
    for (int i = 0; i < 300; i++) begin
      if (ReadData[BUSY] !== 1'b1) break;
      busy++;
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 2 * FRAME) begin n_fail++; $display("FAIL b2b_busy: got %0d cycles expected %0d", busy, 2 * FRAME); end
    n_checks++;
    if (rx_start_q.size() !== 2) begin
      n_fail++; $display("FAIL b2b_frames: got %0d expected 2", rx_start_q.size());
    end else begin
      n_checks++;
      if (rx_start_q[1] - rx_start_q[0] !== FRAME) begin
        n_fail++; $display("FAIL b2b_gap: got start spacing %0d expected %0d", rx_start_q[1] - rx_start_q[0], FRAME);
      end
    end
    while (sb_q.size() > 0 && rx_q.size() > 0) begin
      e = sb_q.pop_front(); g = rx_q.pop_front(); gb = rx_bits_q.pop_front();
      n_checks++;
      if (g !== e || gb !== {1'b1, e, 1'b0}) begin
        n_fail++; $display("FAIL b2b_frame: got bits %b expected %b", gb, {1'b1, e, 1'b0});
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] e, g;
    apply_reset();
    for (int b = 1; b <= 4; b++) begin
      sb_q.push_back(8'(b));
      do_write(8'(b));
    end
    n_checks++;
    if (ReadData[FULL] !== 1'b0) begin n_fail++; $display("FAIL ovf_full_early: got %b expected 0", ReadData[FULL]); end
    sb_q.push_back(8'h05);
    do_write(8'h05);
    n_checks++;
    if (ReadData[FULL] !== 1'b1 || ReadData[OVF] !== 1'b0) begin
      n_fail++; $display("FAIL ovf_full_set: got status %h expected full=1 ovf=0", ReadData);
    end
    do_write(8'h06);
    n_checks++;
    if (ReadData[FULL] !== 1'b1 || ReadData[OVF] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got status %h expected full=1 ovf=1", ReadData);
    end
    wait_idle(6 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ovf_drain: got busy after timeout expected idle"); end
    n_checks++;
    if (ReadData !== 32'hA) begin n_fail++; $display("FAIL ovf_final_status: got %h expected 0000000a", ReadData); end
    n_checks++;
    if (rx_q.size() !== 5) begin n_fail++; $display("FAIL ovf_frames: got %0d expected 5", rx_q.size()); end
    while (sb_q.size() > 0 && rx_q.size() > 0) begin
      e = sb_q.pop_front(); g = rx_q.pop_front(); void'(rx_bits_q.pop_front());
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL ovf_frame: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_push_pop_full();
    bit ok;
    logic [7:0] e, g;
    apply_reset();
    for (int b = 8'h10; b <= 8'h14; b++) begin
      sb_q.push_back(8'(b));
      do_write(8'(b));
    end
    n_checks++;
    if (ReadData !== 32'h5) begin n_fail++; $display("FAIL pp_prefull: got %h expected 00000005", ReadData); end
    repeat (FRAME - 4) @(negedge clk);
    n_checks++;
    if (tx_o !== 1'b1 || ReadData[BUSY] !== 1'b1) begin
      n_fail++; $display("FAIL pp_stop_cycle: got tx=%b status=%h expected tx=1 busy=1", tx_o, ReadData);
    end
    sb_q.push_back(8'h15);
    do_write(8'h15);
    n_checks++;
    if (tx_o !== 1'b0 || ReadData[OVF] !== 1'b0 || ReadData[FULL] !== 1'b1) begin
      n_fail++; $display("FAIL pp_accept: got tx=%b status=%h expected tx=0 full=1 ovf=0", tx_o, ReadData);
    end
    wait_idle(7 * FRAME, ok);
    n_checks++;
    if (!ok || ReadData !== 32'h2) begin n_fail++; $display("FAIL pp_drain: got status %h expected 00000002", ReadData); end
    n_checks++;
    if (rx_q.size() !== 6) begin n_fail++; $display("FAIL pp_frames: got %0d expected 6", rx_q.size()); end
    while (sb_q.size() > 0 && rx_q.size() > 0) begin
      e = sb_q.pop_front(); g = rx_q.pop_front(); void'(rx_bits_q.pop_front());
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL pp_frame: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] first;
    int lows;
    apply_reset();
    first = 8'hC3;
    do_write(first);
    do_write(8'h01);
    do_write(8'h02);
    repeat (16) @(negedge clk);
    n_checks++;
    if (tx_o !== first[3]) begin n_fail++; $display("FAIL mid_bit3: got %b expected %b", tx_o, first[3]); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_o !== 1'b1 || ReadData !== 32'h2) begin
      n_fail++; $display("FAIL mid_reset: got tx=%b status=%h expected tx=1 status=00000002", tx_o, ReadData);
    end
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    n_checks++;
    if (lows !== 0 || rx_q.size() !== 0) begin
      n_fail++; $display("FAIL mid_no_frames: got %0d low cycles %0d frames expected 0 and 0", lows, rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
